temporizador_estado: RTL and testbench
======================================

Name: temporizador_estado

Overview:
- Parametrised successor to the state-to-preset BCD lookup. It loads a per-state duration and counts it down in BCD digits, one digit decrement per divided tick.
- Asserts a one-cycle done pulse on expiry, which the irrigation controller FSM uses to advance state.
- Drives the 7-segment digit decoders directly.
- Sits between the irrigation controller FSM and the display path.

Parameters:
- NUM_DIGITS, 2: number of BCD digits (1..4).
- TICK_DIV, 50000000: clk cycles per count tick (1 Hz at 50 MHz); must be >= 2.
- PRESET_GOTEJANDO, 30: duration in ticks for state 3'b010.
- PRESET_ASPERSAO, 15: duration in ticks for state 3'b011.
- PRESET_LIMPEZA, 5: duration in ticks for state 3'b100.
- PRESET_ERRO, 10: duration in ticks for state 3'b101.
- All presets must be < 10**NUM_DIGITS; an elaboration-time check fails otherwise.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- estado, input, 3: current irrigation state code from the controller FSM.
- habilita, input, 1: count enable. When low, both the tick divider and the count are frozen.
- digitos, output, 4*NUM_DIGITS: BCD count. Digit 0 (units) is in bits [3:0]; digit k is in bits [4k+3:4k].
- ativo, output, 1: high while a nonzero count is running or frozen.
- fim, output, 1: one-cycle pulse when the count reaches 0.

Behaviour:
- Reset values:
  - digitos = 0, ativo = 0, fim = 0.
  - Divider = 0, estado_ant = 3'b000, FSM = OCIOSO.
- estado_ant is a register of estado. A change is detected when estado != estado_ant, registered every cycle.
- Preset mapping matches the display codes. Any other estado code maps to preset 0.
- FSM states and transitions:
  - OCIOSO: ativo = 0.
    - On change to a state with preset > 0: next cycle go to CONTANDO, digitos = BCD(preset), divider = 0.
    - On change to a state with preset 0: digitos = 0, stay in OCIOSO, no fim.
  - CONTANDO: ativo = 1.
    - If habilita = 1, the divider increments each cycle.
    - When divider = TICK_DIV-1: divider returns to 0 and digitos decrements by 1 in BCD with borrow (e.g. 0x10 -> 0x09, 0x30 -> 0x29).
    - If the decrement yields 0: go to OCIOSO and assert fim in that same transition, so fim is high the cycle after the final tick edge.
- Latency:
  - estado change to digitos = preset: 1 cycle.
  - Preset P expires after exactly P*TICK_DIV enabled cycles.
- habilita low: divider and digitos hold and ativo stays 1. Resuming continues from the held divider value, with no tick lost or added.
- Estado change during CONTANDO: the count reloads to the new preset, the divider clears, and no fim is produced for the abandoned count.
- Estado change in the same cycle as the final tick: the reload wins and fim is not asserted.
- A preset of 0 never asserts fim.
- Reset mid-count: all values return to reset values on the next edge and fim is not asserted.
- The divider width is clog2(TICK_DIV). Digit arithmetic never produces a nibble > 9, and the count never wraps below 0.

Optional Feature:
- Macro: TEMPORIZADOR_PAUSA_EN.
- Defined:
  - Adds input port pausa (1 bit).
  - While pausa = 1 in CONTANDO, behaviour matches habilita = 0, plus the ativo output blinks: it toggles every tick period while paused, driven by the still-running divider. The count digits themselves stay frozen.
  - On leaving pause, the divider restarts at 0.
- Not defined:
  - The port is absent, and behaviour is exactly as above.

Decomposition:
- Shared package pkg_irrigacao holds:
  - The estado code constants ESTADO_GOTEJANDO = 3'b010, ESTADO_ASPERSAO = 3'b011, ESTADO_LIMPEZA = 3'b100, ESTADO_ERRO = 3'b101.
  - The timer FSM enum {OCIOSO, CONTANDO}.
  - The function int_to_bcd(value, digits), used for the preset load.
- One natural sub-module: bcd_decrementador. It is combinational, with NUM_DIGITS nibbles in, decremented nibbles out, and a zero flag. It is instantiated once.

Test Plan:
- TICK_DIV = 4, habilita = 1, reset released, estado 000 -> 010:
  - digitos = 0x30 one cycle later.
  - 0x29 after 4 cycles.
  - fim pulses exactly once, 120 cycles after the load; ativo falls with it.
- Count crossing digit borrows: digitos sequence 0x11 -> 0x10 -> 0x09 with no invalid nibble.
  - With NUM_DIGITS = 3 and preset 100: 0x100 -> 0x099.
- habilita low for 7 cycles mid-tick (divider = 2): digitos is held and the next decrement occurs 2 enabled cycles after resume.
- estado 011 -> 100 while digitos = 0x07: reloads to 0x05 with no fim. Changing to 101 on the exact final-tick cycle gives reload 0x10 and no fim.
- reset asserted when digitos = 0x12: next cycle digitos = 0, ativo = 0, fim = 0. estado 000/110/111 gives digitos = 0 with no fim.
- With TEMPORIZADOR_PAUSA_EN defined:
  - pausa = 1 for 12 cycles at digitos 0x08: digits are held and ativo toggles every 4 cycles.
  - After release, the next decrement occurs 4 cycles later.

Source files
------------

// File: rtl/pkg_irrigacao.sv
// Shared irrigation definitions: estado codes, timer FSM states, BCD preset helper.
// Latency: none (constants and an elaboration-time function only).
// Backpressure: not applicable.
package pkg_irrigacao;

    localparam logic [2:0] ESTADO_GOTEJANDO = 3'b010;
    localparam logic [2:0] ESTADO_ASPERSAO  = 3'b011;
    localparam logic [2:0] ESTADO_LIMPEZA   = 3'b100;
    localparam logic [2:0] ESTADO_ERRO      = 3'b101;

    typedef enum logic {
        OCIOSO,
        CONTANDO
    } temp_fsm_t;

    // Packs the low 'digits' decimal digits of 'value' as BCD, units in [3:0].
    // The result is 16 bits wide (four digits maximum); callers slice it down.
    function automatic logic [15:0] int_to_bcd(input int value, input int digits);
        logic [15:0] r;
        int          v;
        r = '0;
        v = value;
        for (int k = 0; k < 4; k++) begin
            if (k < digits) begin
                r[4*k +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_decrementador.sv
// Combinational BCD decrement by one with borrow across digits, plus a zero flag on the result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; an all-zero input passes through unchanged so the count never wraps.
module bcd_decrementador
    import pkg_irrigacao::*;
#(
    parameter int NUM_DIGITS = 2
) (
    input  logic [4*NUM_DIGITS-1:0] din,
    output logic [4*NUM_DIGITS-1:0] dout,
    output logic                    zero
);

    logic borrow;

    // Ripple the borrow from the units digit upwards; a 0 nibble under borrow becomes 9.
    always_comb begin
        dout   = din;
        borrow = |din;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (borrow) begin
                if (din[4*k +: 4] == 4'd0) begin
                    dout[4*k +: 4] = 4'd9;
                end else begin
                    dout[4*k +: 4] = din[4*k +: 4] - 4'd1;
                    borrow         = 1'b0;
                end
            end
        end
        zero = ~|dout;
    end

endmodule

// File: rtl/temporizador_estado.sv
// Per-estado BCD countdown timer: loads a preset on estado change, decrements once per TICK_DIV enabled cycles, pulses fim at zero.
// Latency: estado change -> digitos loaded in 1 cycle; preset P expires after P*TICK_DIV enabled cycles.
// Backpressure: habilita low freezes divider and count; optional TEMPORIZADOR_PAUSA_EN adds pausa (frozen count, blinking ativo).
module temporizador_estado
    import pkg_irrigacao::*;
#(
    parameter int NUM_DIGITS       = 2,
    parameter int TICK_DIV         = 50000000,
    parameter int PRESET_GOTEJANDO = 30,
    parameter int PRESET_ASPERSAO  = 15,
    parameter int PRESET_LIMPEZA   = 5,
    parameter int PRESET_ERRO      = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              estado,
    input  logic                    habilita,
`ifdef TEMPORIZADOR_PAUSA_EN
    input  logic                    pausa,
`endif
    output logic [4*NUM_DIGITS-1:0] digitos,
    output logic                    ativo,
    output logic                    fim
);

    localparam int W     = 4 * NUM_DIGITS;
    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

    localparam logic [15:0] BCD_GOT_F = int_to_bcd(PRESET_GOTEJANDO, NUM_DIGITS);
    localparam logic [15:0] BCD_ASP_F = int_to_bcd(PRESET_ASPERSAO, NUM_DIGITS);
    localparam logic [15:0] BCD_LIM_F = int_to_bcd(PRESET_LIMPEZA, NUM_DIGITS);
    localparam logic [15:0] BCD_ERR_F = int_to_bcd(PRESET_ERRO, NUM_DIGITS);
    localparam logic [W-1:0] BCD_GOT = BCD_GOT_F[W-1:0];
    localparam logic [W-1:0] BCD_ASP = BCD_ASP_F[W-1:0];
    localparam logic [W-1:0] BCD_LIM = BCD_LIM_F[W-1:0];
    localparam logic [W-1:0] BCD_ERR = BCD_ERR_F[W-1:0];

    // Reject configurations the digit field or divider cannot represent.
    generate
        if (NUM_DIGITS < 1 || NUM_DIGITS > 4) begin : g_err_digits
            $error("temporizador_estado: NUM_DIGITS must be 1..4");
        end
        if (TICK_DIV < 2) begin : g_err_div
            $error("temporizador_estado: TICK_DIV must be >= 2");
        end
        if (PRESET_GOTEJANDO >= 10**NUM_DIGITS || PRESET_ASPERSAO >= 10**NUM_DIGITS ||
            PRESET_LIMPEZA >= 10**NUM_DIGITS || PRESET_ERRO >= 10**NUM_DIGITS) begin : g_err_preset
            $error("temporizador_estado: preset does not fit in NUM_DIGITS digits");
        end
    endgenerate

    temp_fsm_t        state_q, state_d;
    logic [W-1:0]     digitos_q, digitos_d;
    logic [DIV_W-1:0] div_q, div_d, div_ref;
    logic [2:0]       estado_ant_q, estado_ant_d;
    logic             fim_q, fim_d;
    logic [W-1:0]     preset_bcd;
    logic [W-1:0]     dec_dat;
    logic             dec_zero;
    logic             mudou;
    logic             em_pausa;
`ifdef TEMPORIZADOR_PAUSA_EN
    logic             pausa_q, pausa_d;
    logic             blink_q, blink_d;
`endif

    bcd_decrementador #(.NUM_DIGITS(NUM_DIGITS)) u_dec (
        .din  (digitos_q),
        .dout (dec_dat),
        .zero (dec_zero)
    );

    assign mudou = (estado != estado_ant_q);

    // Map the current estado code to its BCD preset; unknown codes load zero.
    always_comb begin
        preset_bcd = '0;
        case (estado)
            ESTADO_GOTEJANDO: preset_bcd = BCD_GOT;
            ESTADO_ASPERSAO:  preset_bcd = BCD_ASP;
            ESTADO_LIMPEZA:   preset_bcd = BCD_LIM;
            ESTADO_ERRO:      preset_bcd = BCD_ERR;
            default:          preset_bcd = '0;
        endcase
    end

    // Next-state: a reload on estado change always beats the tick, so an abandoned count never fires fim.
    always_comb begin
        state_d      = state_q;
        digitos_d    = digitos_q;
        estado_ant_d = estado;
        fim_d        = 1'b0;
`ifdef TEMPORIZADOR_PAUSA_EN
        pausa_d  = pausa;
        blink_d  = 1'b0;
        em_pausa = pausa;
        // Leaving pause restarts the tick period from zero.
        div_ref  = (pausa_q && !pausa) ? '0 : div_q;
`else
        em_pausa = 1'b0;
        div_ref  = div_q;
`endif
        div_d = div_ref;

        if (mudou) begin
            digitos_d = preset_bcd;
            div_d     = '0;
            state_d   = (|preset_bcd) ? CONTANDO : OCIOSO;
        end else if (state_q == CONTANDO && em_pausa) begin
`ifdef TEMPORIZADOR_PAUSA_EN
            // Divider keeps running only to pace the ativo blink; digits stay frozen.
            blink_d = blink_q;
            if (habilita) begin
                if (div_q == DIV_MAX) begin
                    div_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
`endif
        end else if (state_q == CONTANDO && habilita) begin
            if (div_ref == DIV_MAX) begin
                div_d     = '0;
                digitos_d = dec_dat;
                if (dec_zero) begin
                    state_d = OCIOSO;
                    fim_d   = 1'b1;
                end
            end else begin
                div_d = div_ref + DIV_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= OCIOSO;
            digitos_q    <= '0;
            div_q        <= '0;
            estado_ant_q <= 3'b000;
            fim_q        <= 1'b0;
`ifdef TEMPORIZADOR_PAUSA_EN
            pausa_q      <= 1'b0;
            blink_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            digitos_q    <= digitos_d;
            div_q        <= div_d;
            estado_ant_q <= estado_ant_d;
            fim_q        <= fim_d;
`ifdef TEMPORIZADOR_PAUSA_EN
            pausa_q      <= pausa_d;
            blink_q      <= blink_d;
`endif
        end
    end

    assign digitos = digitos_q;
    assign fim     = fim_q;
`ifdef TEMPORIZADOR_PAUSA_EN
    assign ativo   = (state_q == CONTANDO) && !blink_q;
`else
    assign ativo   = (state_q == CONTANDO);
`endif

endmodule

// File: tb/tb_temporizador_estado.sv
// Directed bench for temporizador_estado with TICK_DIV=4 (two digits) and a three-digit instance with TICK_DIV=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// The pause scenario is only exercised when TEMPORIZADOR_PAUSA_EN is defined.
module tb_temporizador_estado;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  estado;
    logic        habilita;
    logic [7:0]  digitos;
    logic        ativo;
    logic        fim;
    logic [2:0]  estado3;
    logic [11:0] digitos3;
    logic        ativo3;
    logic        fim3;
`ifdef TEMPORIZADOR_PAUSA_EN
    logic        pausa;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    temporizador_estado #(
        .NUM_DIGITS(2), .TICK_DIV(4),
        .PRESET_GOTEJANDO(30), .PRESET_ASPERSAO(15), .PRESET_LIMPEZA(5), .PRESET_ERRO(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .estado   (estado),
        .habilita (habilita),
`ifdef TEMPORIZADOR_PAUSA_EN
        .pausa    (pausa),
`endif
        .digitos  (digitos),
        .ativo    (ativo),
        .fim      (fim)
    );

    temporizador_estado #(
        .NUM_DIGITS(3), .TICK_DIV(2),
        .PRESET_GOTEJANDO(100), .PRESET_ASPERSAO(15), .PRESET_LIMPEZA(5), .PRESET_ERRO(10)
    ) dut3 (
        .clk      (clk),
        .reset    (reset),
        .estado   (estado3),
        .habilita (1'b1),
`ifdef TEMPORIZADOR_PAUSA_EN
        .pausa    (1'b0),
`endif
        .digitos  (digitos3),
        .ativo    (ativo3),
        .fim      (fim3)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic nib_ok(input logic [11:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) && (d[11:8] <= 4'd9);
    endfunction

    task automatic test_reset();
        reset = 1'b1; estado = 3'b000; estado3 = 3'b000; habilita = 1'b1;
`ifdef TEMPORIZADOR_PAUSA_EN
        pausa = 1'b0;
`endif
        step(2);
        checks++; if (digitos !== 8'h00) begin failures++; $display("FAIL reset_digitos got=%h exp=00", digitos); end
        checks++; if (ativo !== 1'b0) begin failures++; $display("FAIL reset_ativo got=%b exp=0", ativo); end
        checks++; if (fim !== 1'b0) begin failures++; $display("FAIL reset_fim got=%b exp=0", fim); end
        checks++; if (digitos3 !== 12'h000) begin failures++; $display("FAIL reset_digitos3 got=%h exp=000", digitos3); end
        reset = 1'b0;
        step();
        checks++; if (digitos !== 8'h00 || ativo !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=%h/%b exp=00/0", digitos, ativo); end
    endtask

    task automatic test_three_digits();
        estado3 = 3'b010;
        step();
        checks++; if (digitos3 !== 12'h100 || ativo3 !== 1'b1) begin failures++; $display("FAIL load3 got=%h/%b exp=100/1", digitos3, ativo3); end
        step();
        checks++; if (digitos3 !== 12'h100) begin failures++; $display("FAIL hold3 got=%h exp=100", digitos3); end
        step();
        checks++; if (digitos3 !== 12'h099 || !nib_ok(digitos3)) begin failures++; $display("FAIL borrow3 got=%h exp=099", digitos3); end
    endtask

    task automatic test_load_and_expiry();
        int first; int pulses; logic [7:0] d_at; logic a_at;
        first = -1; pulses = 0; d_at = 8'hff; a_at = 1'b1;
        estado = 3'b010;
        step();
        checks++; if (digitos !== 8'h30 || ativo !== 1'b1) begin failures++; $display("FAIL load got=%h/%b exp=30/1", digitos, ativo); end
        step(3);
        checks++; if (digitos !== 8'h30) begin failures++; $display("FAIL pre_tick got=%h exp=30", digitos); end
        step();
        checks++; if (digitos !== 8'h29) begin failures++; $display("FAIL first_tick got=%h exp=29", digitos); end
        for (int c = 5; c <= 130; c++) begin
            step();
            if (fim === 1'b1) begin
                pulses++;
                if (first < 0) begin first = c; d_at = digitos; a_at = ativo; end
            end
        end
        checks++; if (first != 120) begin failures++; $display("FAIL fim_cycle got=%0d exp=120", first); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL fim_pulses got=%0d exp=1", pulses); end
        checks++; if (a_at !== 1'b0 || d_at !== 8'h00) begin failures++; $display("FAIL fim_outputs got=%h/%b exp=00/0", d_at, a_at); end
    endtask

    task automatic test_borrow();
        int bad; logic [7:0] d16, d20, d24;
        bad = 0; d16 = '0; d20 = '0; d24 = '0;
        estado = 3'b011;
        step();
        checks++; if (digitos !== 8'h15) begin failures++; $display("FAIL load15 got=%h exp=15", digitos); end
        for (int c = 1; c <= 32; c++) begin
            step();
            if (!nib_ok({4'h0, digitos})) bad++;
            if (c == 16) d16 = digitos;
            if (c == 20) d20 = digitos;
            if (c == 24) d24 = digitos;
        end
        checks++; if (d16 !== 8'h11) begin failures++; $display("FAIL seq11 got=%h exp=11", d16); end
        checks++; if (d20 !== 8'h10) begin failures++; $display("FAIL seq10 got=%h exp=10", d20); end
        checks++; if (d24 !== 8'h09) begin failures++; $display("FAIL seq09 got=%h exp=09", d24); end
        checks++; if (bad != 0) begin failures++; $display("FAIL nibble_range got=%0d exp=0", bad); end
        checks++; if (digitos !== 8'h07) begin failures++; $display("FAIL at07 got=%h exp=07", digitos); end
    endtask

    task automatic test_reload();
        estado = 3'b100;
        step();
        checks++; if (digitos !== 8'h05 || fim !== 1'b0) begin failures++; $display("FAIL reload05 got=%h/%b exp=05/0", digitos, fim); end
    endtask

    task automatic test_habilita();
        int held_bad;
        held_bad = 0;
        step(2);
        habilita = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (digitos !== 8'h05 || ativo !== 1'b1) held_bad++;
        end
        checks++; if (held_bad != 0) begin failures++; $display("FAIL hold_habilita got=%0d exp=0", held_bad); end
        habilita = 1'b1;
        step();
        checks++; if (digitos !== 8'h05) begin failures++; $display("FAIL resume1 got=%h exp=05", digitos); end
        step();
        checks++; if (digitos !== 8'h04) begin failures++; $display("FAIL resume2 got=%h exp=04", digitos); end
    endtask

    task automatic test_final_tick_reload();
        int f;
        f = 0;
        step(12);
        checks++; if (digitos !== 8'h01) begin failures++; $display("FAIL at01 got=%h exp=01", digitos); end
        step(3);
        estado = 3'b101;
        step();
        if (fim === 1'b1) f++;
        checks++; if (digitos !== 8'h10 || ativo !== 1'b1) begin failures++; $display("FAIL final_reload got=%h/%b exp=10/1", digitos, ativo); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (fim === 1'b1) f++;
        end
        checks++; if (f != 0) begin failures++; $display("FAIL final_reload_fim got=%0d exp=0", f); end
    endtask

    task automatic test_reset_mid();
        estado = 3'b011;
        step(13);
        checks++; if (digitos !== 8'h12) begin failures++; $display("FAIL at12 got=%h exp=12", digitos); end
        reset = 1'b1; estado = 3'b000;
        step();
        checks++; if (digitos !== 8'h00 || ativo !== 1'b0 || fim !== 1'b0) begin failures++; $display("FAIL reset_mid got=%h/%b/%b exp=00/0/0", digitos, ativo, fim); end
        reset = 1'b0;
        step();
        checks++; if (digitos !== 8'h00 || ativo !== 1'b0) begin failures++; $display("FAIL post_reset got=%h/%b exp=00/0", digitos, ativo); end
    endtask

    task automatic test_preset_zero();
        int f;
        f = 0;
        estado = 3'b110;
        step();
        if (fim === 1'b1) f++;
        checks++; if (digitos !== 8'h00 || ativo !== 1'b0) begin failures++; $display("FAIL zero110 got=%h/%b exp=00/0", digitos, ativo); end
        estado = 3'b111; step(); if (fim === 1'b1) f++;
        estado = 3'b000; step(); if (fim === 1'b1) f++;
        estado = 3'b010;
        step();
        checks++; if (digitos !== 8'h30) begin failures++; $display("FAIL reload30 got=%h exp=30", digitos); end
        estado = 3'b110;
        step();
        if (fim === 1'b1) f++;
        checks++; if (digitos !== 8'h00 || ativo !== 1'b0) begin failures++; $display("FAIL abort_to_zero got=%h/%b exp=00/0", digitos, ativo); end
        step(3);
        if (fim === 1'b1) f++;
        checks++; if (f != 0) begin failures++; $display("FAIL zero_fim got=%0d exp=0", f); end
    endtask

`ifdef TEMPORIZADOR_PAUSA_EN
    task automatic test_pausa();
        int bad; logic a4, a8, a12;
        bad = 0; a4 = 1'bx; a8 = 1'bx; a12 = 1'bx;
        estado = 3'b011;
        step(29);
        checks++; if (digitos !== 8'h08) begin failures++; $display("FAIL at08 got=%h exp=08", digitos); end
        pausa = 1'b1;
        for (int p = 1; p <= 12; p++) begin
            step();
            if (digitos !== 8'h08) bad++;
            if (p == 4) a4 = ativo;
            if (p == 8) a8 = ativo;
            if (p == 12) a12 = ativo;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL pausa_hold got=%0d exp=0", bad); end
        checks++; if (a4 !== 1'b0 || a8 !== 1'b1 || a12 !== 1'b0) begin failures++; $display("FAIL pausa_blink got=%b%b%b exp=010", a4, a8, a12); end
        pausa = 1'b0;
        step(3);
        checks++; if (digitos !== 8'h08) begin failures++; $display("FAIL pausa_resume3 got=%h exp=08", digitos); end
        step();
        checks++; if (digitos !== 8'h07) begin failures++; $display("FAIL pausa_resume4 got=%h exp=07", digitos); end
    endtask
`endif

    initial begin
        test_reset();
        test_three_digits();
        test_load_and_expiry();
        test_borrow();
        test_reload();
        test_habilita();
        test_final_tick_reload();
        test_reset_mid();
        test_preset_zero();
`ifdef TEMPORIZADOR_PAUSA_EN
        test_pausa();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
